// File: rtl/uart_prgm_loader_if.sv
// Programming-port bundle for uart_prgm_loader.
//   master : the loader. Receives uart_rx/done/clr_err and drives the write port and status.
//   slave  : the host side, i.e. the EEPROM programming logic plus the serial source.
// Signals:
//   uart_rx    serial input, idle high, asynchronous to the clock
//   done       EEPROM transaction complete (level)
//   clr_err    synchronous clear of the sticky error flags
//   prgm_addr  word address of the write in progress
//   prgm_in    data byte of the write in progress
//   go         one-cycle write strobe
//   busy       high from go until the rising edge of done
//   frame_err  sticky: stop bit sampled low
//   proto_err  sticky: bad address nibble, bad checksum or inter-byte timeout
//   overrun    sticky: byte received while busy
//   wr_count   completed writes, saturating at 31
interface uart_prgm_loader_if;
  logic       uart_rx;
  logic       done;
  logic       clr_err;
  logic [3:0] prgm_addr;
  logic [7:0] prgm_in;
  logic       go;
  logic       busy;
  logic       frame_err;
  logic       proto_err;
  logic       overrun;
  logic [4:0] wr_count;

  modport master (
    input  uart_rx, done, clr_err,
    output prgm_addr, prgm_in, go, busy, frame_err, proto_err, overrun, wr_count
  );

  modport slave (
    output uart_rx, done, clr_err,
    input  prgm_addr, prgm_in, go, busy, frame_err, proto_err, overrun, wr_count
  );
endinterface

// File: rtl/uart_prgm_loader.sv
// Serial program loader for the 16-word EEPROM programming port.
// Receives 8N1 UART frames, parses 4-byte packets {0xA5, ADDR, DATA, SUM} with
// SUM = ADDR ^ DATA and ADDR[7:4] = 0, then issues one write (go strobe) and holds
// busy until a fresh rising edge of done, so only one write is ever outstanding.
// Ports:
//   clk_i   system clock, all logic on posedge
//   rst_ni  asynchronous active-low reset
//   bus     uart_prgm_loader_if.master (serial in, done handshake, write port, status flags)
module uart_prgm_loader #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input logic               clk_i,
  input logic               rst_ni,
  uart_prgm_loader_if.master bus
);

  localparam int unsigned BitCyc     = CLK_HZ / BAUD;
  localparam int unsigned HalfCyc    = BitCyc / 2;
  localparam int unsigned TimeoutCyc = TIMEOUT_BITS * BitCyc;
  localparam int unsigned CntW       = $clog2(BitCyc + 1);
  localparam int unsigned ToW        = $clog2(TimeoutCyc + 1);

  localparam logic [CntW-1:0] BitLast  = CntW'(BitCyc - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfCyc - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TimeoutCyc - 1);
  localparam logic [7:0]      Header   = 8'hA5;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_st_e;
  typedef enum logic [2:0] {PHdr, PAddr, PData, PSum, PWait} p_st_e;

  // RX synchroniser; resets to the idle-high line level.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX FSM
  rx_st_e          rx_st_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic            frame_drop_q;
  logic            frame_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st_q      <= RxIdle;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_drop_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_drop_q <= 1'b0;
      // A coincident framing error below overrides this clear.
      if (bus.clr_err) frame_err_q <= 1'b0;
      unique case (rx_st_q)
        RxIdle: begin
          if (!rx_sync_q) begin
            rx_st_q   <= RxStart;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            rx_st_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == BitLast) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) rx_st_q <= RxStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            rx_st_q <= RxIdle;
            if (rx_sync_q) begin
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q  <= 1'b1;
              frame_drop_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= RxIdle;
      endcase
    end
  end

  // Parser FSM
  p_st_e          p_st_q;
  logic [3:0]     addr_q;
  logic [7:0]     data_q;
  logic [3:0]     prgm_addr_q;
  logic [7:0]     prgm_in_q;
  logic           go_q;
  logic           busy_q;
  logic           done_q;
  logic           proto_err_q;
  logic           overrun_q;
  logic [4:0]     wr_count_q;
  logic [ToW-1:0] to_cnt_q;

  logic in_pkt;
  logic timeout_hit;
  logic done_rise;

  assign in_pkt      = (p_st_q == PAddr) || (p_st_q == PData) || (p_st_q == PSum);
  assign timeout_hit = in_pkt && !byte_valid_q && (to_cnt_q == ToLast);
  assign done_rise   = bus.done && !done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_st_q      <= PHdr;
      addr_q      <= '0;
      data_q      <= '0;
      prgm_addr_q <= '0;
      prgm_in_q   <= '0;
      go_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_count_q  <= '0;
      to_cnt_q    <= '0;
    end else begin
      go_q   <= 1'b0;
      done_q <= bus.done;
      if (bus.clr_err) begin
        proto_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      // Inter-byte timer restarts on every received byte while a packet is open.
      if (in_pkt && !byte_valid_q) to_cnt_q <= to_cnt_q + 1'b1;
      else                         to_cnt_q <= '0;

      // A framing error aborts a partial packet; an issued write is left to finish
      // so busy cannot be stranded high.
      if (frame_drop_q && (p_st_q != PWait)) begin
        p_st_q <= PHdr;
      end else if (timeout_hit) begin
        proto_err_q <= 1'b1;
        p_st_q      <= PHdr;
      end else begin
        unique case (p_st_q)
          PHdr: begin
            if (byte_valid_q && (shift_q == Header)) p_st_q <= PAddr;
          end
          PAddr: begin
            if (byte_valid_q) begin
              if (shift_q[7:4] != 4'h0) begin
                proto_err_q <= 1'b1;
                p_st_q      <= PHdr;
              end else begin
                addr_q <= shift_q[3:0];
                p_st_q <= PData;
              end
            end
          end
          PData: begin
            if (byte_valid_q) begin
              data_q <= shift_q;
              p_st_q <= PSum;
            end
          end
          PSum: begin
            if (byte_valid_q) begin
              if (shift_q == ({4'h0, addr_q} ^ data_q)) begin
                prgm_addr_q <= addr_q;
                prgm_in_q   <= data_q;
                go_q        <= 1'b1;
                busy_q      <= 1'b1;
                p_st_q      <= PWait;
              end else begin
                proto_err_q <= 1'b1;
                p_st_q      <= PHdr;
              end
            end
          end
          PWait: begin
            if (byte_valid_q) overrun_q <= 1'b1;
            // Only an edge seen after go counts; a level already high is ignored.
            if (done_rise) begin
              busy_q <= 1'b0;
              if (wr_count_q != 5'd31) wr_count_q <= wr_count_q + 5'd1;
              p_st_q <= PHdr;
            end
          end
          default: p_st_q <= PHdr;
        endcase
      end
    end
  end

  assign bus.prgm_addr = prgm_addr_q;
  assign bus.prgm_in   = prgm_in_q;
  assign bus.go        = go_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.proto_err = proto_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_uart_prgm_loader.sv
// Self-checking bench for uart_prgm_loader at CLK_HZ=1600, BAUD=100 (16 clocks per bit).
// Expected writes are queued when a valid packet is sent and compared when go fires.
module tb_uart_prgm_loader;

  localparam int BitCyc = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_prgm_loader_if bus();

  uart_prgm_loader #(
    .CLK_HZ      (1600),
    .BAUD        (100),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         go_count = 0;
  int         exp_wr   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.uart_rx = 1'b0;
    tick(BitCyc);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      tick(BitCyc);
    end
    bus.uart_rx = stop;
    tick(BitCyc);
    bus.uart_rx = 1'b1;
    if (!stop) tick(2 * BitCyc);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input logic [7:0] s);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    send_byte(s, 1'b1);
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    tick(1);
  endtask

  task automatic complete_write();
    int n = 0;
    while (bus.busy !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    check("busy_before_done", bus.busy, 1);
    tick(3);
    bus.done = 1'b1;
    tick(3);
    bus.done = 1'b0;
    tick(2);
    if (exp_wr < 31) exp_wr++;
    check("busy_after_done", bus.busy, 0);
    check("wr_count", bus.wr_count, exp_wr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, bus.prgm_addr, 0);
    check({tag, "_in"}, bus.prgm_in, 0);
    check({tag, "_go"}, bus.go, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ferr"}, bus.frame_err, 0);
    check({tag, "_perr"}, bus.proto_err, 0);
    check({tag, "_ovr"}, bus.overrun, 0);
    check({tag, "_wrc"}, bus.wr_count, 0);
  endtask

  // Scoreboard: every go must match the oldest queued write.
  always @(negedge clk) begin
    if (rst_n && bus.go === 1'b1) begin
      logic [11:0] e;
      go_count++;
      check("go_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("go_addr", bus.prgm_addr, e[11:8]);
        check("go_data", bus.prgm_in, e[7:0]);
        check("go_busy", bus.busy, 1);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    int g;
    bus.uart_rx = 1'b1;
    bus.done    = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(5);

    // Basic write
    push_exp(4'h3, 8'h5C);
    send_pkt(8'h03, 8'h5C, 8'h5F);
    tick(2);
    check("t1_addr", bus.prgm_addr, 4'h3);
    check("t1_data", bus.prgm_in, 8'h5C);
    check("t1_busy", bus.busy, 1);
    check("t1_gos", go_count, 1);
    complete_write();

    // Bad checksum, then a valid packet
    send_pkt(8'h02, 8'h11, 8'h00);
    tick(3);
    check("t2_perr", bus.proto_err, 1);
    check("t2_nogo", go_count, 1);
    check("t2_hold_addr", bus.prgm_addr, 4'h3);
    check("t2_hold_data", bus.prgm_in, 8'h5C);
    clear_err();
    check("t2_clr", bus.proto_err, 0);
    push_exp(4'h7, 8'h9C);
    send_pkt(8'h07, 8'h9C, 8'h9B);
    complete_write();

    // Bad address nibble, parser resyncs on next header
    send_byte(8'hA5, 1'b1);
    send_byte(8'h13, 1'b1);
    tick(2);
    check("t3_perr", bus.proto_err, 1);
    check("t3_busy", bus.busy, 0);
    clear_err();
    push_exp(4'h5, 8'h33);
    send_pkt(8'h05, 8'h33, 8'h36);
    complete_write();

    // Inter-byte timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    tick(18 * BitCyc);
    check("t4_pre_timeout", bus.proto_err, 0);
    tick(4 * BitCyc);
    check("t4_timeout", bus.proto_err, 1);
    clear_err();
    push_exp(4'h4, 8'hAA);
    send_pkt(8'h04, 8'hAA, 8'hAE);
    complete_write();
    check("t4_addr", bus.prgm_addr, 4'h4);

    // Framing error, then a start-bit glitch inside a packet
    send_byte(8'h55, 1'b0);
    check("t5_ferr", bus.frame_err, 1);
    check("t5_perr", bus.proto_err, 0);
    clear_err();
    check("t5_ferr_clr", bus.frame_err, 0);
    push_exp(4'h6, 8'h44);
    send_byte(8'hA5, 1'b1);
    bus.uart_rx = 1'b0;
    tick(4);
    bus.uart_rx = 1'b1;
    tick(2 * BitCyc);
    check("t5_glitch_ferr", bus.frame_err, 0);
    send_byte(8'h06, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h42, 1'b1);
    complete_write();
    check("t5_gos", go_count, 5);

    // done already high at go must not complete the write
    push_exp(4'h9, 8'h12);
    bus.done = 1'b1;
    send_pkt(8'h09, 8'h12, 8'h1B);
    tick(20);
    check("stale_done_busy", bus.busy, 1);
    bus.done = 1'b0;
    tick(2);
    check("stale_done_busy2", bus.busy, 1);
    complete_write();

    // Overrun while busy
    push_exp(4'hA, 8'h5A);
    send_pkt(8'h0A, 8'h5A, 8'h50);
    send_byte(8'h77, 1'b1);
    tick(2);
    check("t6_ovr", bus.overrun, 1);
    check("t6_busy", bus.busy, 1);
    complete_write();
    clear_err();
    check("t6_ovr_clr", bus.overrun, 0);

    // Reset mid-packet
    g = go_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    bus.uart_rx = 1'b0;
    tick(2 * BitCyc);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    bus.uart_rx = 1'b1;
    tick(3);
    rst_n  = 1'b1;
    exp_wr = 0;
    tick(30 * BitCyc);
    check("midrst_nogo", go_count, g);
    check("midrst_wrc", bus.wr_count, 0);
    check("midrst_queue", exp_q.size(), 0);

    // Saturation of the write counter
    for (int i = 0; i < 32; i++) begin
      a = 8'(i % 16);
      d = 8'($urandom_range(0, 255));
      push_exp(a[3:0], d);
      send_pkt(a, d, a ^ d);
      complete_write();
    end
    check("sat_wrc", bus.wr_count, 31);
    check("sat_addr", bus.prgm_addr, 4'hF);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
